// File: rtl/packet_mem_to_tx.sv
// packet_mem_to_tx: pops packet lengths, streams the matching SRAM bytes onto TX with an enforced inter-frame gap
module packet_mem_to_tx #(
  parameter int pFIFO_WIDTH = 16,
  parameter int pDATA_WIDTH = 8,
  parameter int pDEPTH_RAM  = 3072,
  parameter int pADDR_WIDTH = 12,
  parameter int pMAX_LEN    = 1536,
  parameter int pIFG        = 12
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  input  logic                   ienable,
  input  logic                   ilen_empty,
  input  logic [pFIFO_WIDTH-1:0] ilen_data,
  output logic                   olen_rd,
  output logic [pADDR_WIDTH-1:0] oram_addr,
  input  logic [pDATA_WIDTH-1:0] iram_data,
  output logic                   otx_en,
  output logic [pDATA_WIDTH-1:0] otxd,
  output logic                   otx_er,
  output logic [pADDR_WIDTH-1:0] orel_ptr,
  output logic                   obusy,
  output logic                   odrop
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] POP  = 3'd1;
  localparam logic [2:0] LEN  = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] GAP  = 3'd4;
  localparam int IW = $clog2(pIFG + 1);
  localparam int SW = pFIFO_WIDTH + 1;

  logic [2:0]             state_q, state_d;
  logic                   len_rd_q, len_rd_d;
  logic                   drop_q, drop_d;
  logic                   tx_en_q, tx_en_d;
  logic [pDATA_WIDTH-1:0] txd_q, txd_d;
  logic                   tx_er_q;
  logic [pADDR_WIDTH-1:0] addr_q, addr_d;
  logic [pADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [pADDR_WIDTH-1:0] rel_q, rel_d;
  logic [pFIFO_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]          ifg_q, ifg_d;
  logic                   av_q, av_d;
  logic                   dv_q, dv_d;
  logic [SW-1:0]          drop_sum;
  logic [pADDR_WIDTH-1:0] drop_ptr, rd_inc;

  // Discarded lengths may exceed the SRAM several times over, so the skip needs a true modulo.
  assign drop_sum = SW'(rd_ptr_q) + SW'(ilen_data);
  assign drop_ptr = pADDR_WIDTH'(drop_sum % SW'(pDEPTH_RAM));
  assign rd_inc   = (rd_ptr_q == pADDR_WIDTH'(pDEPTH_RAM - 1)) ? '0 : rd_ptr_q + pADDR_WIDTH'(1);

  assign olen_rd   = len_rd_q;
  assign odrop     = drop_q;
  assign otx_en    = tx_en_q;
  assign otxd      = txd_q;
  assign otx_er    = tx_er_q;
  assign oram_addr = addr_q;
  assign orel_ptr  = rel_q;
  assign obusy     = state_q != IDLE;

  // Next state: av tracks an address on the SRAM bus, dv tracks its data arriving a cycle later.
  always_comb begin
    state_d  = state_q;
    len_rd_d = 1'b0;
    drop_d   = 1'b0;
    tx_en_d  = 1'b0;
    txd_d    = '0;
    addr_d   = addr_q;
    rd_ptr_d = rd_ptr_q;
    rel_d    = rel_q;
    cnt_d    = cnt_q;
    ifg_d    = ifg_q;
    av_d     = 1'b0;
    dv_d     = av_q;
    case (state_q)
      IDLE: begin
        if (!ilen_empty && ienable) begin
          len_rd_d = 1'b1;
          state_d  = POP;
        end
      end
      POP: state_d = LEN;
      LEN: begin
        if (ilen_data == '0) begin
          state_d = IDLE;
        end else if (ilen_data > pFIFO_WIDTH'(pMAX_LEN)) begin
          rd_ptr_d = drop_ptr;
          rel_d    = drop_ptr;
          drop_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          addr_d   = rd_ptr_q;
          rd_ptr_d = rd_inc;
          cnt_d    = ilen_data - pFIFO_WIDTH'(1);
          av_d     = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        tx_en_d = dv_q;
        txd_d   = dv_q ? iram_data : '0;
        if (cnt_q != '0) begin
          addr_d   = rd_ptr_q;
          rd_ptr_d = rd_inc;
          cnt_d    = cnt_q - pFIFO_WIDTH'(1);
          av_d     = 1'b1;
        end
        if (dv_q && !av_q) begin
          rel_d   = rd_ptr_q;
          ifg_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (ifg_q == IW'(pIFG - 1)) state_d = IDLE;
        else ifg_d = ifg_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight frame immediately.
  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      len_rd_q <= 1'b0;
      drop_q   <= 1'b0;
      tx_en_q  <= 1'b0;
      txd_q    <= '0;
      tx_er_q  <= 1'b0;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      rel_q    <= '0;
      cnt_q    <= '0;
      ifg_q    <= '0;
      av_q     <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_rd_q <= len_rd_d;
      drop_q   <= drop_d;
      tx_en_q  <= tx_en_d;
      txd_q    <= txd_d;
      tx_er_q  <= 1'b0;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      rel_q    <= rel_d;
      cnt_q    <= cnt_d;
      ifg_q    <= ifg_d;
      av_q     <= av_d;
      dv_q     <= dv_d;
    end
  end
endmodule
